demux1to16_seq: RTL and testbench
=================================

Name: demux1to16_seq

Overview:
- Registered 1-to-16 demultiplexer/deserializer. It is the receive-side inverse of the 16:1 mux tree.
- Routes a single-bit input stream into a 16-bit output register, bit by bit.
- Two routing modes:
  - Sequential: an internal pointer auto-increments from 0 to 15.
  - Addressed: an external sel chooses the target bit.
- Signals when all 16 positions are written, then holds the word until the consumer acknowledges it.

Parameters:
- N, 16, number of output bits; must be a power of 2, minimum 2.
- SEL_W, 4, select/pointer width; must equal log2(N).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = addressed (use sel), 1 = sequential (use internal pointer).
- sel  in  SEL_W  target bit index in addressed mode; ignored in sequential mode.
- d  in  1  data bit.
- d_valid  in  1  d is presented this cycle.
- d_ready  out  1  block can accept d this cycle.
- clear  in  1  abort current frame; clear the written mask and pointer.
- frame_ack  in  1  consumer has taken y; release HOLD.
- y  out  N  demultiplexed word.
- written  out  N  per-bit mask; bit k set once y[k] has been written in the current frame.
- ptr  out  SEL_W  current sequential pointer.
- frame_done  out  1  high while a complete word is held (state HOLD).

Behaviour:
- Reset (rst=1 at an edge):
  - y=0, written=0, ptr=0, mode_r=0.
  - State goes to FILL; frame_done=0.
  - d_ready is forced to 0 while rst is high.
  - Reset mid-frame discards all partial data.
- States: FILL (accepting bits), HOLD (word complete, waiting for frame_ack).
- d_ready = (state==FILL) && !clear && !rst. It is combinational, with no dependency on d_valid.
- Accept occurs on the edge where d_valid && d_ready. On accept:
  - Target index t = mode_r ? ptr : sel.
  - y[t] <= d; written[t] <= 1.
  - In sequential mode, ptr <= ptr+1. ptr wraps 15->0 on the final bit of a frame.
- Mode latch:
  - mode_r <= mode only on edges where written==0, i.e. at frame start.
  - Toggling mode mid-frame has no effect until the next frame.
  - When written==0, the accept target in that same cycle uses the incoming mode value.
- Latency: an accepted bit is visible on y and written one cycle after the accepting edge.
- Addressed-mode overwrite: re-writing an already-written index updates y[t]; written is unchanged. Frame completion requires all 16 distinct indices.
- FILL -> HOLD: on the edge where the accept makes written all-ones. frame_done rises the following cycle.
- In HOLD:
  - d_ready=0 and d is ignored.
  - y is stable.
  - frame_done=1.
- HOLD -> FILL: on an edge with frame_ack=1. Then:
  - written <= 0, ptr <= 0.
  - y retains its value until overwritten bit by bit.
  - frame_ack in FILL is ignored.
- clear (any state):
  - written <= 0, ptr <= 0, state <= FILL; y is retained.
  - clear has priority over a simultaneous accept (d_ready is already 0) and over frame_ack.
- rst has priority over clear.
- Width rules:
  - ptr arithmetic is modulo N.
  - The decoder produces exactly one one-hot write enable per accept and none otherwise.

Decomposition:
- Package demux_pkg holds:
  - constants N_DEF=16, SEL_W_DEF=4;
  - state encoding FILL=1'b0, HOLD=1'b1;
  - the all-ones mask constant.
- Sub-module demux1to16_dec: SEL_W-to-N one-hot decoder with enable (en, idx -> we[N-1:0]). It is instantiated once to generate the y/written write enables.
- The top level holds the FSM, pointer, mode latch and registers.

Test Plan:
- Reset, then sequential mode: feed 16 accepted bits of pattern 0xA5C3, LSB first, with d_valid held high. Required response:
  - y=16'hA5C3 and frame_done=1 one cycle after the 16th accept.
  - ptr=0; d_ready=0 thereafter.
  - 2 extra d_valid cycles leave y unchanged.
- Addressed mode: write sel=15,0,7,… in shuffled order, covering all 16, with d=1 only at sel=3 and sel=12. Also rewrite sel=7 twice before completion. Required response:
  - frame_done only after the 16th distinct index.
  - y=16'h1008.
- In HOLD, assert frame_ack for 1 cycle. Required response:
  - next cycle written=0, ptr=0, frame_done=0, d_ready=1;
  - y is still 16'h1008 until the next accept.
- Sequential mode: after 5 accepts, assert clear together with d_valid=1. Required response:
  - d_ready=0 that cycle;
  - next cycle written=0, ptr=0;
  - the bit presented with clear is not written.
- Toggle mode from 1 to 0 after 3 sequential accepts, then drive sel=9. Required response:
  - the write still lands at ptr=3 (mode_r unchanged);
  - after clear, the new mode=0 takes effect and sel=9 writes y[9].
- Assert rst mid-frame (8 bits written, y nonzero). Required response:
  - next cycle y=0, written=0, ptr=0, frame_done=0;
  - d_ready=0 while rst is high, then 1.

Source files
------------

// File: rtl/demux1to16_seq_pkg.sv
// demux_pkg: shared constants and state encoding for the 1-to-16 registered
// demultiplexer/deserializer.
//   N_DEF / SEL_W_DEF : default word width and select/pointer width
//   state_t           : FSM encoding (FILL accepting bits, HOLD word complete)
//   ALL_ONES          : completed-frame mask at the default width
package demux_pkg;

    localparam int N_DEF     = 16;
    localparam int SEL_W_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [N_DEF-1:0] ALL_ONES = '1;

endpackage

// File: rtl/demux1to16_seq_if.sv
// demux1to16_seq_if: bus between the bit-stream producer/word consumer
// (master) and the demultiplexer (slave).
//   master drives : mode, sel, d, d_valid, clear, frame_ack
//   slave drives  : d_ready, y, written, ptr, frame_done
interface demux1to16_seq_if
    import demux_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int SEL_W = SEL_W_DEF
);

    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             d;
    logic             d_valid;
    logic             d_ready;
    logic             clear;
    logic             frame_ack;
    logic [N-1:0]     y;
    logic [N-1:0]     written;
    logic [SEL_W-1:0] ptr;
    logic             frame_done;

    modport master (
        output mode, sel, d, d_valid, clear, frame_ack,
        input  d_ready, y, written, ptr, frame_done
    );

    modport slave (
        input  mode, sel, d, d_valid, clear, frame_ack,
        output d_ready, y, written, ptr, frame_done
    );

endinterface

// File: rtl/demux1to16_seq_dec.sv
// demux1to16_dec: SEL_W-to-N one-hot decoder with enable.
//   en  : in,  produce a write enable this cycle
//   idx : in,  bit index to enable
//   we  : out, one-hot when en=1, all zero otherwise
module demux1to16_dec
    import demux_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             en,
    input  logic [SEL_W-1:0] idx,
    output logic [N-1:0]     we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1to16_seq.sv
// demux1to16_seq: registered 1-to-N demultiplexer. Bits arriving on bus.d are
// routed into y either at an auto-incrementing pointer (mode=1) or at bus.sel
// (mode=0). Once every position has been written the word is held until
// frame_ack.
//   clk : in, rising-edge clock
//   rst : in, synchronous active-high reset
//   bus : slave side of demux1to16_seq_if
//
// state | meaning
// FILL  | accepting bits, written mask not yet full
// HOLD  | complete word held on y, waiting for frame_ack
module demux1to16_seq
    import demux_pkg::*;
#(
    parameter int N     = N_DEF,   // power of two, >= 2
    parameter int SEL_W = SEL_W_DEF // log2(N)
) (
    input  logic            clk,
    input  logic            rst,
    demux1to16_seq_if.slave bus
);

    localparam logic [N-1:0] FULL = {N{1'b1}};

    state_t           state_q, state_d;
    logic [N-1:0]     y_q, y_d;
    logic [N-1:0]     written_q, written_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             mode_r_q, mode_r_d;

    logic             frame_start;
    logic             mode_eff;
    logic             d_ready;
    logic             accept;
    logic [SEL_W-1:0] tgt;
    logic [N-1:0]     we;

    // At frame start the mode latch is transparent, so the first bit of a
    // frame already follows the incoming mode.
    assign frame_start = (written_q == '0);
    assign mode_eff    = frame_start ? bus.mode : mode_r_q;
    assign d_ready     = (state_q == FILL) && !bus.clear && !rst;
    assign accept      = bus.d_valid && d_ready;
    assign tgt         = mode_eff ? ptr_q : bus.sel;

    demux1to16_dec #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (accept),
        .idx (tgt),
        .we  (we)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = (y_q & ~we) | ({N{bus.d}} & we);
        written_d = written_q | we;
        ptr_d     = ptr_q;
        mode_r_d  = frame_start ? bus.mode : mode_r_q;

        // Pointer is SEL_W wide, so the increment wraps modulo N.
        if (accept && mode_eff) begin
            ptr_d = ptr_q + 1'b1;
        end
        if (accept && (written_d == FULL)) begin
            state_d = HOLD;
        end

        // clear beats frame_ack; an accept cannot coincide with clear.
        if (bus.clear) begin
            written_d = '0;
            ptr_d     = '0;
            state_d   = FILL;
        end else if ((state_q == HOLD) && bus.frame_ack) begin
            written_d = '0;
            ptr_d     = '0;
            state_d   = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            y_q       <= '0;
            written_q <= '0;
            ptr_q     <= '0;
            mode_r_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            written_q <= written_d;
            ptr_q     <= ptr_d;
            mode_r_q  <= mode_r_d;
        end
    end

    assign bus.d_ready    = d_ready;
    assign bus.y          = y_q;
    assign bus.written    = written_q;
    assign bus.ptr        = ptr_q;
    assign bus.frame_done = (state_q == HOLD);

endmodule

// File: tb/tb_demux1to16_seq.sv
// Self-checking bench for demux1to16_seq: directed scenarios followed by
// random traffic, compared each cycle against a bit-array reference model.
module tb_demux1to16_seq;

    logic clk;
    logic rst;

    demux1to16_seq_if bus ();

    demux1to16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: word and mask as plain bit arrays, pointer as integer.
    bit m_y [16];
    bit m_wr[16];
    int m_ptr  = 0;
    bit m_mode = 1'b0;
    bit m_hold = 1'b0;

    function automatic logic [15:0] pack16(input bit a[16]);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = a[i];
        return r;
    endfunction

    function automatic int count_wr();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_wr[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input bit v, input bit dd, input bit md, input int s,
                              input bit clr, input bit ack, input bit r);
        int  cnt;
        bit  eff;
        int  t;
        cnt = count_wr();
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_y[i]  = 1'b0;
                m_wr[i] = 1'b0;
            end
            m_ptr  = 0;
            m_mode = 1'b0;
            m_hold = 1'b0;
        end else begin
            eff = (cnt == 0) ? md : m_mode;
            if (cnt == 0) m_mode = md;
            if (clr) begin
                for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
                m_ptr  = 0;
                m_hold = 1'b0;
            end else if (m_hold) begin
                if (ack) begin
                    for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
                    m_ptr  = 0;
                    m_hold = 1'b0;
                end
            end else if (v) begin
                t = eff ? m_ptr : s;
                m_y[t]  = dd;
                m_wr[t] = 1'b1;
                if (eff) m_ptr = (m_ptr + 1) % 16;
                if (count_wr() == 16) m_hold = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, check d_ready mid-cycle, update model on the
    // edge, then check registered outputs just after it.
    task automatic cycle(input bit v, input bit dd, input bit md, input int s,
                         input bit clr, input bit ack, input bit r);
        bus.d_valid   = v;
        bus.d         = dd;
        bus.mode      = md;
        bus.sel       = 4'(s);
        bus.clear     = clr;
        bus.frame_ack = ack;
        rst           = r;
        @(negedge clk);
        chk("d_ready", {31'b0, bus.d_ready}, {31'b0, (!m_hold && !clr && !r)});
        @(posedge clk);
        model_edge(v, dd, md, s, clr, ack, r);
        #1;
        chk("y", {16'b0, bus.y}, {16'b0, pack16(m_y)});
        chk("written", {16'b0, bus.written}, {16'b0, pack16(m_wr)});
        chk("ptr", {28'b0, bus.ptr}, m_ptr);
        chk("frame_done", {31'b0, bus.frame_done}, {31'b0, m_hold});
    endtask

    initial begin
        logic [15:0] pat;
        int          order[18];
        bit          r_mode;

        bus.d_valid = 0; bus.d = 0; bus.mode = 0; bus.sel = 0;
        bus.clear = 0; bus.frame_ack = 0; rst = 1;

        // Reset
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("rst_y", {16'b0, bus.y}, 32'h0);
        chk("rst_done", {31'b0, bus.frame_done}, 32'h0);

        // Sequential frame 0xA5C3, LSB first
        pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("seq_not_done_early", {31'b0, bus.frame_done}, 32'h0);
            cycle(1, pat[i], 1, 0, 0, 0, 0);
        end
        chk("seq_y", {16'b0, bus.y}, 32'hA5C3);
        chk("seq_done", {31'b0, bus.frame_done}, 32'h1);
        chk("seq_ptr", {28'b0, bus.ptr}, 32'h0);
        chk("seq_rdy_low", {31'b0, bus.d_ready}, 32'h0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        chk("hold_y_stable", {16'b0, bus.y}, 32'hA5C3);

        // Release, then addressed frame with rewrites of index 7
        cycle(0, 0, 0, 0, 0, 1, 0);
        order = '{15, 0, 7, 3, 7, 12, 1, 14, 2, 7, 13, 4, 11, 5, 10, 6, 9, 8};
        for (int i = 0; i < 18; i++) begin
            if (i == 17) chk("addr_not_done_early", {31'b0, bus.frame_done}, 32'h0);
            cycle(1, (order[i] == 3 || order[i] == 12), 0, order[i], 0, 0, 0);
        end
        chk("addr_y", {16'b0, bus.y}, 32'h1008);
        chk("addr_done", {31'b0, bus.frame_done}, 32'h1);

        // frame_ack
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("ack_written", {16'b0, bus.written}, 32'h0);
        chk("ack_ptr", {28'b0, bus.ptr}, 32'h0);
        chk("ack_done", {31'b0, bus.frame_done}, 32'h0);
        chk("ack_rdy", {31'b0, bus.d_ready}, 32'h1);
        chk("ack_y", {16'b0, bus.y}, 32'h1008);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Clear after 5 sequential accepts; bit presented with clear dropped
        for (int i = 0; i < 5; i++) cycle(1, i[0], 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 1, 0, 0);
        chk("clr_written", {16'b0, bus.written}, 32'h0);
        chk("clr_ptr", {28'b0, bus.ptr}, 32'h0);
        chk("clr_bit5_kept", {31'b0, bus.y[5]}, 32'h0);

        // Mode toggle mid-frame is ignored until the next frame
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 9, 0, 0, 0);
        chk("tog_written", {16'b0, bus.written}, 32'h000F);
        chk("tog_ptr", {28'b0, bus.ptr}, 32'h4);
        cycle(0, 0, 0, 9, 1, 0, 0);
        cycle(1, 1, 0, 9, 0, 0, 0);
        chk("tog_sel9_written", {16'b0, bus.written}, 32'h0200);
        chk("tog_sel9_y", {31'b0, bus.y[9]}, 32'h1);
        chk("tog_sel9_ptr", {28'b0, bus.ptr}, 32'h0);

        // Reset mid-frame
        cycle(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0, 0, 0);
        chk("pre_rst_written", {16'b0, bus.written}, 32'h00FF);
        cycle(1, 1, 1, 0, 0, 0, 1);
        chk("mid_rst_y", {16'b0, bus.y}, 32'h0);
        chk("mid_rst_written", {16'b0, bus.written}, 32'h0);
        chk("mid_rst_ptr", {28'b0, bus.ptr}, 32'h0);
        chk("mid_rst_done", {31'b0, bus.frame_done}, 32'h0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_rdy", {31'b0, bus.d_ready}, 32'h1);

        // Random traffic against the model
        r_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) r_mode = ~r_mode;
            cycle($urandom_range(0, 3) != 0, 1'($urandom), r_mode,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
